// File: rtl/wots_chain_gen_pkg.sv
// rtl/wots_chain_gen_pkg.sv - shared constants, FSM encoding and helpers for the WOTS chain generator
package wots_chain_gen_pkg;

    localparam int DEF_SEED_NUM    = 67;
    localparam int DEF_KEY_LEN     = 256;
    localparam int DEF_CHAIN_STEPS = 15;
    localparam int MSG_LEN         = 1024;
    localparam int STEP_W          = 16;

    localparam logic [255:0] DEF_PADDING_F = 256'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_HSTART,
        ST_HWAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Address width that stays at least one bit for single-entry memories.
    function automatic int clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wots_chain_gen.sv
// rtl/wots_chain_gen.sv - iterates the WOTS chaining hash over every seed and stores the chain ends
module wots_chain_gen
    import wots_chain_gen_pkg::*;
#(
    parameter int           SEED_NUM            = DEF_SEED_NUM,
    parameter int           KEY_LEN             = DEF_KEY_LEN,
    parameter int           CHAIN_STEPS         = DEF_CHAIN_STEPS,
    parameter logic [255:0] XMSS_HASH_PADDING_F = DEF_PADDING_F
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [KEY_LEN-1:0]          pub_key,
    output logic                        busy,
    output logic                        done,
    output logic                        seed_mem_rd_en,
    output logic [clog2(SEED_NUM)-1:0]  seed_mem_rd_addr,
    input  logic [KEY_LEN-1:0]          seed_mem_rd_data,
    output logic                        hash_start,
    output logic [MSG_LEN-1:0]          hash_data_in,
    output logic                        message_length,
    input  logic                        hash_done,
    input  logic [KEY_LEN-1:0]          hash_data_out,
    output logic                        pk_mem_wr_en,
    output logic [clog2(SEED_NUM)-1:0]  pk_mem_wr_addr,
    output logic [KEY_LEN-1:0]          pk_wr_data
);

    localparam int                AW        = clog2(SEED_NUM);
    localparam logic [AW-1:0]     LAST_IDX  = AW'(SEED_NUM - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CHAIN_STEPS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       idx;
    logic [STEP_W-1:0]   step;
    logic [KEY_LEN-1:0]  chain_reg;
    logic [KEY_LEN-1:0]  key_reg;
    logic [15:0]         idx_ext;
    logic                last_idx;
    logic                last_step;

    assign last_idx  = (idx == LAST_IDX);
    assign last_step = (step == LAST_STEP);
    assign idx_ext   = 16'(idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_RD;
            ST_RD:      state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = (CHAIN_STEPS == 0) ? ST_WRITE : ST_HSTART;
            ST_HSTART:  state_nxt = ST_HWAIT;
            ST_HWAIT:   if (hash_done) state_nxt = last_step ? ST_WRITE : ST_HSTART;
            ST_WRITE:   state_nxt = last_idx ? ST_DONE : ST_RD;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Registers only move on state-qualified events, so the hash message stays put across HWAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            step      <= '0;
            chain_reg <= '0;
            key_reg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_reg <= pub_key;
                        idx     <= '0;
                        step    <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    chain_reg <= seed_mem_rd_data;
                    step      <= '0;
                end
                ST_HWAIT: begin
                    if (hash_done) begin
                        chain_reg <= hash_data_out;
                        if (!last_step) step <= step + 16'd1;
                    end
                end
                ST_WRITE: begin
                    if (!last_idx) idx <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
    assign seed_mem_rd_en   = (state == ST_RD);
    assign seed_mem_rd_addr = idx;
    assign hash_start       = (state == ST_HSTART);
    assign message_length   = 1'b1;
    assign pk_mem_wr_en     = (state == ST_WRITE);
    assign pk_mem_wr_addr   = idx;
    assign pk_wr_data       = chain_reg;

    assign hash_data_in = {XMSS_HASH_PADDING_F, key_reg, chain_reg, 224'b0, idx_ext, step};

endmodule

// File: tb/tb_wots_chain_gen.sv
// tb/tb_wots_chain_gen.sv - randomized self-checking bench for wots_chain_gen with a chain-level reference model
module tb_wots_chain_gen;

    localparam int N = 4;
    localparam int H = 3;

    logic           clk;
    logic           reset;
    logic           start      [2];
    logic [255:0]   pub_key    [2];
    logic           busy       [2];
    logic           done       [2];
    logic           rd_en      [2];
    logic [1:0]     rd_addr    [2];
    logic [255:0]   rd_data    [2];
    logic           hstart     [2];
    logic [1023:0]  hdin       [2];
    logic           mlen       [2];
    logic           hdone      [2];
    logic [255:0]   hdout      [2];
    logic           wr_en      [2];
    logic [1:0]     wr_addr    [2];
    logic [255:0]   wr_data    [2];

    int             steps      [2] = '{2, 0};
    logic [255:0]   seedmem    [2][N];
    logic [255:0]   pkmem      [2][N];
    logic [1023:0]  msgq       [$];

    int             n_cmp = 0;
    int             n_fail = 0;

    // reference model state (one chain generator per instance)
    bit             running    [2];
    int             cyc        [2];
    int             widx       [2];
    int             ri         [2];
    int             rs         [2];
    int             hcnt       [2];
    logic [255:0]   mkey       [2];

    // hash / memory responder state
    int             pend       [2];
    logic [1023:0]  hmsg       [2];
    logic           prev_rd    [2];
    logic [1:0]     prev_addr  [2];

    wots_chain_gen #(.SEED_NUM(N), .KEY_LEN(256), .CHAIN_STEPS(2), .XMSS_HASH_PADDING_F(256'h0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .pub_key(pub_key[0]), .busy(busy[0]), .done(done[0]),
        .seed_mem_rd_en(rd_en[0]), .seed_mem_rd_addr(rd_addr[0]), .seed_mem_rd_data(rd_data[0]),
        .hash_start(hstart[0]), .hash_data_in(hdin[0]), .message_length(mlen[0]),
        .hash_done(hdone[0]), .hash_data_out(hdout[0]),
        .pk_mem_wr_en(wr_en[0]), .pk_mem_wr_addr(wr_addr[0]), .pk_wr_data(wr_data[0])
    );

    wots_chain_gen #(.SEED_NUM(N), .KEY_LEN(256), .CHAIN_STEPS(0), .XMSS_HASH_PADDING_F(256'h0)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .pub_key(pub_key[1]), .busy(busy[1]), .done(done[1]),
        .seed_mem_rd_en(rd_en[1]), .seed_mem_rd_addr(rd_addr[1]), .seed_mem_rd_data(rd_data[1]),
        .hash_start(hstart[1]), .hash_data_in(hdin[1]), .message_length(mlen[1]),
        .hash_done(hdone[1]), .hash_data_out(hdout[1]),
        .pk_mem_wr_en(wr_en[1]), .pk_mem_wr_addr(wr_addr[1]), .pk_wr_data(wr_data[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Seed memory (one-cycle read latency) and a hash engine returning chain+1 after H wait cycles.
    initial begin
        for (int d = 0; d < 2; d++) begin
            hdone[d] = 1'b0; hdout[d] = '0; rd_data[d] = '0;
            pend[d] = 0; prev_rd[d] = 1'b0; prev_addr[d] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                rd_data[d]   = prev_rd[d] ? seedmem[d][prev_addr[d]] : rand256();
                prev_rd[d]   = rd_en[d];
                prev_addr[d] = rd_addr[d];
                hdone[d]     = 1'b0;
                hdout[d]     = rand256();
                if (!reset) begin
                    pend[d] = 0;
                end else if (hstart[d]) begin
                    pend[d] = H;
                    hmsg[d] = hdin[d];
                    if (d == 0) msgq.push_back(hdin[d]);
                end else if (pend[d] > 0) begin
                    pend[d]--;
                    if (pend[d] == 0) begin
                        hdone[d] = 1'b1;
                        hdout[d] = hmsg[d][511:256] + 256'd1;
                    end
                end else if (!busy[d] && $urandom_range(0, 7) == 0) begin
                    hdone[d] = 1'b1;
                end
            end
        end
    end

    // Chain-level model: after s hashes a chain holds seed+s; requests and writes follow index order.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("message_length", 1024'(mlen[d]), 1024'd1);
            if (!reset) begin
                running[d] = 1'b0;
                chk("reset_ctrl", 1024'({busy[d], done[d], rd_en[d], hstart[d], wr_en[d], rd_addr[d], wr_addr[d]}), 1024'd0);
                chk("reset_hash_data_in", hdin[d], 1024'd0);
                chk("reset_pk_wr_data", 1024'(wr_data[d]), 1024'd0);
            end else begin
                if (running[d]) cyc[d]++;
                chk("busy", 1024'(busy[d]), 1024'(running[d]));
                if (rd_en[d]) chk("rd_addr", 1024'({running[d], rd_addr[d]}), 1024'({1'b1, 2'(widx[d])}));
                if (hstart[d]) begin
                    chk("hash_req_legal", 1024'(running[d] && ri[d] < N && steps[d] > 0), 1024'd1);
                    if (ri[d] < N)
                        chk("hash_data_in", hdin[d],
                            {256'h0, mkey[d], seedmem[d][ri[d]] + 256'(rs[d]), 224'h0, 16'(ri[d]), 16'(rs[d])});
                    hcnt[d]++;
                    rs[d]++;
                    if (rs[d] >= steps[d]) begin
                        rs[d] = 0;
                        ri[d]++;
                    end
                end
                if (wr_en[d]) begin
                    chk("pk_wr_legal", 1024'(running[d] && widx[d] < N), 1024'd1);
                    if (widx[d] < N) begin
                        chk("pk_wr_addr", 1024'(wr_addr[d]), 1024'(widx[d]));
                        chk("pk_wr_data", 1024'(wr_data[d]), 1024'(seedmem[d][widx[d]] + 256'(steps[d])));
                        pkmem[d][widx[d]] = wr_data[d];
                    end
                    widx[d]++;
                end
                if (done[d]) begin
                    chk("done_writes", 1024'(widx[d]), 1024'(N));
                    chk("done_hashes", 1024'(hcnt[d]), 1024'(N * steps[d]));
                    chk("done_latency", 1024'(cyc[d]), 1024'(N * (3 + steps[d] * (1 + H)) + 1));
                    running[d] = 1'b0;
                end else if (!running[d] && start[d]) begin
                    running[d] = 1'b1;
                    cyc[d] = 0; widx[d] = 0; ri[d] = 0; rs[d] = 0; hcnt[d] = 0;
                    mkey[d] = pub_key[d];
                end
            end
        end
    end

    task automatic run(input int d, input logic [255:0] key, input bit pulse, output int n);
        bit got = 1'b0;
        @(posedge clk); #1;
        pub_key[d] = key;
        start[d]   = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            n++;
            start[d]   = pulse && (n == 6);
            pub_key[d] = rand256();
            if (done[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("run_timeout", 1024'(got), 1024'd1);
    endtask

    initial begin
        int n;
        int n2;
        int dd;
        bit found;
        int exp_a [N] = '{12, 22, 32, 42};
        logic [255:0] key;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            pub_key[d] = '0;
            for (int i = 0; i < N; i++) begin
                seedmem[d][i] = '0;
                pkmem[d][i] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // fixed seeds 10..40, two hashes each
        for (int i = 0; i < N; i++) seedmem[0][i] = 256'(10 * (i + 1));
        msgq.delete();
        key = rand256();
        run(0, key, 1'b0, n);
        chk("a_latency", 1024'(n), 1024'd45);
        for (int i = 0; i < N; i++) chk("a_pk", 1024'(pkmem[0][i]), 1024'(exp_a[i]));
        chk("a_nreq", 1024'(msgq.size()), 1024'd8);
        if (msgq.size() >= 3) begin
            chk("a_req0_pad", 1024'(msgq[0][1023:768]), 1024'd0);
            chk("a_req0_key", 1024'(msgq[0][767:512]), 1024'(key));
            chk("a_req0_chain", 1024'(msgq[0][511:256]), 1024'd10);
            chk("a_req0_idx_step", 1024'(msgq[0][255:0]), 1024'd0);
            chk("a_req1_idx_step", 1024'(msgq[1][31:0]), 1024'h0000_0001);
            chk("a_req1_chain", 1024'(msgq[1][511:256]), 1024'd11);
            chk("a_req2_idx_step", 1024'(msgq[2][31:0]), 1024'h0001_0000);
        end

        // zero-step chains copy seeds straight through
        for (int i = 0; i < N; i++) seedmem[1][i] = rand256();
        run(1, rand256(), 1'b0, n);
        chk("b_latency", 1024'(n), 1024'd13);
        for (int i = 0; i < N; i++) chk("b_pk", 1024'(pkmem[1][i]), 1024'(seedmem[1][i]));
        chk("b_no_hash", 1024'(hcnt[1]), 1024'd0);

        // start pulsed while busy must not restart
        run(1, rand256(), 1'b1, n);
        chk("c_latency", 1024'(n), 1024'd13);

        // asynchronous reset during the second hash of index 1
        for (int i = 0; i < N; i++) seedmem[0][i] = rand256();
        @(posedge clk); #1;
        pub_key[0] = rand256();
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (hstart[0] && hdin[0][31:0] == 32'h0001_0001) begin
                found = 1'b1;
                break;
            end
        end
        chk("d_reach_hash", 1024'(found), 1024'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("d_async_ctrl", 1024'({busy[0], hstart[0], rd_en[0], wr_en[0], done[0]}), 1024'd0);
        chk("d_async_msg", hdin[0], 1024'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        run(0, rand256(), 1'b0, n);
        chk("d_restart_latency", 1024'(n), 1024'd45);

        // back-to-back runs with a fresh pub_key
        run(0, rand256(), 1'b0, n);
        run(0, rand256(), 1'b0, n2);
        chk("e_b2b_latency", 1024'(n2), 1024'(n));

        for (int k = 0; k < 4; k++) begin
            dd = $urandom_range(0, 1);
            for (int i = 0; i < N; i++) seedmem[dd][i] = rand256();
            run(dd, rand256(), 1'($urandom_range(0, 1)), n);
            chk("r_latency", 1024'(n), 1024'(N * (3 + steps[dd] * (1 + H)) + 1));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
